// File: rtl/hex_display_scanner_pkg.sv
// Shared types and constants for the multiplexed hex display scanner.
// Latency: n/a (types, constants and a width helper only).
// Backpressure: n/a.
package hex_disp_pkg;

  typedef enum logic {
    BLANK = 1'b0,
    DRIVE = 1'b1
  } state_t;

  localparam logic [6:0] SEG_OFF  = 7'h7F;
  localparam int         NIBBLE_W = 4;

  // $clog2 that never yields a zero-width vector (for counts of 1 or 2).
  function automatic int clog2_min1(input int v);
    return (v <= 2) ? 1 : $clog2(v);
  endfunction

endpackage

// File: rtl/hex_display_scanner_if.sv
// Load handshake, digit enables and display outputs of the scanner.
// Latency: n/a (wiring only).
// Backpressure: load_valid is held by the master until load_ready is seen.
// Ports: load_data/load_valid/load_ready (new display word), digit_en (live
// per-digit enables), seg_n/dig_n (active-low display bus), frame_done (pulse).
interface hex_display_scanner_if #(
  parameter int NUM_DIGITS = 4
);
  logic [4*NUM_DIGITS-1:0] load_data;
  logic                    load_valid;
  logic                    load_ready;
  logic [NUM_DIGITS-1:0]   digit_en;
  logic [6:0]              seg_n;
  logic [NUM_DIGITS-1:0]   dig_n;
  logic                    frame_done;

  modport master (
    output load_data, load_valid, digit_en,
    input  load_ready, seg_n, dig_n, frame_done
  );

  modport slave (
    input  load_data, load_valid, digit_en,
    output load_ready, seg_n, dig_n, frame_done
  );
endinterface

// File: rtl/hex_display_scanner_seven_seg_decoder.sv
// Hex nibble to active-low seven-segment pattern (bit0 = a ... bit6 = g).
// Latency: combinational.
// Backpressure: none.
// Ports: hex (4-bit value in), seg_n (7-bit active-low pattern out).
module seven_seg_decoder
  import hex_disp_pkg::*;
(
  input  logic [NIBBLE_W-1:0] hex,
  output logic [6:0]          seg_n
);

  always_comb begin
    seg_n = SEG_OFF;
    case (hex)
      4'h0: seg_n = 7'h40;
      4'h1: seg_n = 7'h79;
      4'h2: seg_n = 7'h24;
      4'h3: seg_n = 7'h30;
      4'h4: seg_n = 7'h19;
      4'h5: seg_n = 7'h12;
      4'h6: seg_n = 7'h02;
      4'h7: seg_n = 7'h78;
      4'h8: seg_n = 7'h00;
      4'h9: seg_n = 7'h10;
      4'hA: seg_n = 7'h08;
      4'hB: seg_n = 7'h03;
      4'hC: seg_n = 7'h46;
      4'hD: seg_n = 7'h21;
      4'hE: seg_n = 7'h06;
      4'hF: seg_n = 7'h0E;
      default: seg_n = SEG_OFF;
    endcase
  end

endmodule

// File: rtl/hex_display_scanner.sv
// Time-multiplexes NUM_DIGITS hex nibbles onto one decoder with a blank gap per slot.
// Latency: outputs registered; first digit-0 strobe BLANK_CYC cycles after reset release.
// Backpressure: load_ready = pending buffer empty; a held word commits at the frame wrap.
// Ports: clk, resetn (synchronous, active-low), bus (hex_display_scanner_if.slave).
// Option: define LEADING_ZERO_BLANK_EN to darken leading zero digits (digit 0 always shown).
module hex_display_scanner
  import hex_disp_pkg::*;
#(
  parameter int NUM_DIGITS = 4,
  parameter int DWELL_CYC  = 1000,
  parameter int BLANK_CYC  = 16
) (
  input  logic                  clk,
  input  logic                  resetn,
  hex_display_scanner_if.slave  bus
);

  localparam int MAX_CYC = (DWELL_CYC > BLANK_CYC) ? DWELL_CYC : BLANK_CYC;
  localparam int CNT_W   = clog2_min1(MAX_CYC);
  localparam int IDX_W   = clog2_min1(NUM_DIGITS);
  localparam int DATA_W  = NIBBLE_W * NUM_DIGITS;

  localparam logic [CNT_W-1:0] DWELL_LAST = CNT_W'(DWELL_CYC - 1);
  localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'(BLANK_CYC - 1);
  localparam logic [IDX_W-1:0] IDX_LAST   = IDX_W'(NUM_DIGITS - 1);

  state_t              state_q, state_nxt;
  logic [CNT_W-1:0]    cnt_q, cnt_nxt;
  logic [IDX_W-1:0]    idx_q, idx_nxt;
  logic [DATA_W-1:0]   active_q, pending_q;
  logic                pending_full_q;
  logic [6:0]          seg_q, seg_nxt;
  logic [NUM_DIGITS-1:0] dig_q, dig_nxt;
  logic                frame_done_q;

  logic                slot_end, wrap, accept, show;
  logic [NIBBLE_W-1:0] cur_nib;
  logic [6:0]          cur_seg;
  logic [NUM_DIGITS-1:0] suppress;

  assign accept         = bus.load_valid & ~pending_full_q;
  assign bus.load_ready = ~pending_full_q;
  assign bus.seg_n      = seg_q;
  assign bus.dig_n      = dig_q;
  assign bus.frame_done = frame_done_q;

  assign cur_nib = active_q[int'(idx_q)*NIBBLE_W +: NIBBLE_W];

  seven_seg_decoder u_dec (
    .hex   (cur_nib),
    .seg_n (cur_seg)
  );

`ifdef LEADING_ZERO_BLANK_EN
  // Walk down from the top digit; a digit stays dark while it and every digit
  // above it are zero. Digit 0 is outside the loop so it is always shown.
  logic zero_run;
  always_comb begin
    suppress = '0;
    zero_run = 1'b1;
    for (int i = NUM_DIGITS - 1; i >= 1; i--) begin
      zero_run    = zero_run & (active_q[i*NIBBLE_W +: NIBBLE_W] == '0);
      suppress[i] = zero_run;
    end
  end
`else
  assign suppress = '0;
`endif

  // A disabled or suppressed digit still consumes its slot, keeping brightness uniform.
  assign show = bus.digit_en[idx_q] & ~suppress[idx_q];

  always_comb begin
    slot_end  = (state_q == BLANK) ? (cnt_q == BLANK_LAST) : (cnt_q == DWELL_LAST);
    wrap      = (state_q == DRIVE) && slot_end && (idx_q == IDX_LAST);
    state_nxt = state_q;
    cnt_nxt   = cnt_q + 1'b1;
    idx_nxt   = idx_q;
    if (slot_end) begin
      cnt_nxt   = '0;
      state_nxt = (state_q == BLANK) ? DRIVE : BLANK;
      if (state_q == DRIVE) begin
        idx_nxt = (idx_q == IDX_LAST) ? '0 : idx_q + 1'b1;
      end
    end
    // idx only moves when leaving DRIVE, so idx_q is the digit of any DRIVE cycle ahead.
    seg_nxt = SEG_OFF;
    dig_nxt = '1;
    if (state_nxt == DRIVE && show) begin
      seg_nxt        = cur_seg;
      dig_nxt[idx_q] = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q        <= BLANK;
      cnt_q          <= '0;
      idx_q          <= '0;
      active_q       <= '0;
      pending_q      <= '0;
      pending_full_q <= 1'b0;
      seg_q          <= SEG_OFF;
      dig_q          <= '1;
      frame_done_q   <= 1'b0;
    end else begin
      state_q      <= state_nxt;
      cnt_q        <= cnt_nxt;
      idx_q        <= idx_nxt;
      seg_q        <= seg_nxt;
      dig_q        <= dig_nxt;
      frame_done_q <= wrap;
      // accept needs an empty buffer and commit needs a full one, so they never collide.
      if (accept) begin
        pending_q      <= bus.load_data;
        pending_full_q <= 1'b1;
      end else if (wrap && pending_full_q) begin
        active_q       <= pending_q;
        pending_full_q <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_hex_display_scanner.sv
// Directed bench for hex_display_scanner with NUM_DIGITS=4, DWELL_CYC=4, BLANK_CYC=2.
// Cycle k means "just after the k-th rising edge following the last reset edge".
module tb_hex_display_scanner;

  logic clk = 1'b0;
  logic resetn = 1'b0;
  int   tests = 0;
  int   fails = 0;
  int   cyc   = 0;

  hex_display_scanner_if #(.NUM_DIGITS(4)) bus ();

  hex_display_scanner #(
    .NUM_DIGITS (4),
    .DWELL_CYC  (4),
    .BLANK_CYC  (2)
  ) dut (
    .clk    (clk),
    .resetn (resetn),
    .bus    (bus)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic run_to(input int k);
    while (cyc < k) step();
  endtask

  task automatic do_reset();
    resetn         = 1'b0;
    bus.load_valid = 1'b0;
    bus.load_data  = '0;
    bus.digit_en   = 4'hF;
    repeat (3) step();
    resetn = 1'b1;
    cyc    = 0;
  endtask

  task automatic load_word(input logic [15:0] w);
    bus.load_data  = w;
    bus.load_valid = 1'b1;
    step();
    bus.load_valid = 1'b0;
  endtask

  task automatic test_reset();
    resetn = 1'b0; bus.load_valid = 1'b0; bus.load_data = '0; bus.digit_en = 4'hF;
    repeat (3) step();
    tests++; if (bus.seg_n !== 7'h7F) begin fails++; $display("FAIL reset_seg: got %h want 7f", bus.seg_n); end
    tests++; if (bus.dig_n !== 4'hF) begin fails++; $display("FAIL reset_dig: got %h want f", bus.dig_n); end
    tests++; if (bus.load_ready !== 1'b1) begin fails++; $display("FAIL reset_ready: got %b want 1", bus.load_ready); end
    tests++; if (bus.frame_done !== 1'b0) begin fails++; $display("FAIL reset_fd: got %b want 0", bus.frame_done); end
    resetn = 1'b1; cyc = 0;
    run_to(1);
    tests++; if (bus.dig_n !== 4'hF) begin fails++; $display("FAIL reset_blank_k1: got %h want f", bus.dig_n); end
    run_to(2);
    tests++; if (bus.dig_n !== 4'hE || bus.seg_n !== 7'h40) begin fails++; $display("FAIL reset_first_strobe: dig %h seg %h want e 40", bus.dig_n, bus.seg_n); end
  endtask

  task automatic test_load();
    do_reset();
    load_word(16'h1234);
    tests++; if (bus.load_ready !== 1'b0) begin fails++; $display("FAIL load_ready_drop: got %b want 0", bus.load_ready); end
    run_to(8);
    tests++; if (bus.dig_n !== 4'hD || bus.seg_n !== 7'h40) begin fails++; $display("FAIL load_f1_d1: dig %h seg %h want d 40", bus.dig_n, bus.seg_n); end
    run_to(23);
    tests++; if (bus.frame_done !== 1'b0 || bus.load_ready !== 1'b0) begin fails++; $display("FAIL load_k23: fd %b rdy %b want 0 0", bus.frame_done, bus.load_ready); end
    run_to(24);
    tests++; if (bus.frame_done !== 1'b1 || bus.load_ready !== 1'b1 || bus.dig_n !== 4'hF) begin fails++; $display("FAIL load_wrap: fd %b rdy %b dig %h want 1 1 f", bus.frame_done, bus.load_ready, bus.dig_n); end
    run_to(25);
    tests++; if (bus.frame_done !== 1'b0) begin fails++; $display("FAIL load_fd_pulse: got %b want 0", bus.frame_done); end
    run_to(26);
    tests++; if (bus.dig_n !== 4'hE || bus.seg_n !== 7'h19) begin fails++; $display("FAIL load_f2_d0: dig %h seg %h want e 19", bus.dig_n, bus.seg_n); end
    run_to(32);
    tests++; if (bus.dig_n !== 4'hD || bus.seg_n !== 7'h30) begin fails++; $display("FAIL load_f2_d1: dig %h seg %h want d 30", bus.dig_n, bus.seg_n); end
    run_to(44);
    tests++; if (bus.dig_n !== 4'h7 || bus.seg_n !== 7'h79) begin fails++; $display("FAIL load_f2_d3: dig %h seg %h want 7 79", bus.dig_n, bus.seg_n); end
  endtask

  task automatic test_backpressure();
    do_reset();
    load_word(16'h1234);
    bus.load_data = 16'hABCD; bus.load_valid = 1'b1;
    run_to(23);
    tests++; if (bus.load_ready !== 1'b0) begin fails++; $display("FAIL bp_held: rdy %b want 0", bus.load_ready); end
    run_to(24);
    tests++; if (bus.load_ready !== 1'b1) begin fails++; $display("FAIL bp_ready_rise: rdy %b want 1", bus.load_ready); end
    run_to(25);
    bus.load_valid = 1'b0;
    tests++; if (bus.load_ready !== 1'b0) begin fails++; $display("FAIL bp_accept: rdy %b want 0", bus.load_ready); end
    run_to(26);
    tests++; if (bus.seg_n !== 7'h19) begin fails++; $display("FAIL bp_f2_d0: seg %h want 19", bus.seg_n); end
    run_to(48);
    tests++; if (bus.frame_done !== 1'b1) begin fails++; $display("FAIL bp_f2_wrap: fd %b want 1", bus.frame_done); end
    run_to(50);
    tests++; if (bus.dig_n !== 4'hE || bus.seg_n !== 7'h21) begin fails++; $display("FAIL bp_f3_d0: dig %h seg %h want e 21", bus.dig_n, bus.seg_n); end
    run_to(68);
    tests++; if (bus.dig_n !== 4'h7 || bus.seg_n !== 7'h08) begin fails++; $display("FAIL bp_f3_d3: dig %h seg %h want 7 08", bus.dig_n, bus.seg_n); end
  endtask

  task automatic test_digit_en();
    do_reset();
    bus.digit_en = 4'b1011;
    run_to(8);
    tests++; if (bus.dig_n !== 4'hD) begin fails++; $display("FAIL en_d1: dig %h want d", bus.dig_n); end
    for (int k = 14; k <= 17; k++) begin
      run_to(k);
      tests++; if (bus.dig_n !== 4'hF) begin fails++; $display("FAIL en_d2_dark k=%0d: dig %h want f", k, bus.dig_n); end
    end
    run_to(20);
    tests++; if (bus.dig_n !== 4'h7 || bus.seg_n !== 7'h40) begin fails++; $display("FAIL en_d3: dig %h seg %h want 7 40", bus.dig_n, bus.seg_n); end
    run_to(24);
    tests++; if (bus.frame_done !== 1'b1) begin fails++; $display("FAIL en_period: fd %b want 1", bus.frame_done); end
    bus.digit_en = 4'hF;
  endtask

  task automatic test_reset_mid();
    do_reset();
    load_word(16'h1234);
    run_to(15);
    tests++; if (bus.dig_n !== 4'hB || bus.load_ready !== 1'b0) begin fails++; $display("FAIL mid_pre: dig %h rdy %b want b 0", bus.dig_n, bus.load_ready); end
    resetn = 1'b0;
    step();
    tests++; if (bus.dig_n !== 4'hF || bus.seg_n !== 7'h7F || bus.load_ready !== 1'b1 || bus.frame_done !== 1'b0) begin
      fails++; $display("FAIL mid_reset: dig %h seg %h rdy %b fd %b want f 7f 1 0", bus.dig_n, bus.seg_n, bus.load_ready, bus.frame_done);
    end
    resetn = 1'b1; cyc = 0;
    run_to(1);
    tests++; if (bus.dig_n !== 4'hF) begin fails++; $display("FAIL mid_blank: dig %h want f", bus.dig_n); end
    run_to(2);
    tests++; if (bus.dig_n !== 4'hE) begin fails++; $display("FAIL mid_restart: dig %h want e", bus.dig_n); end
    run_to(26);
    tests++; if (bus.seg_n !== 7'h40) begin fails++; $display("FAIL mid_discard: seg %h want 40", bus.seg_n); end
  endtask

  task automatic test_zero_blank();
    do_reset();
    load_word(16'h0050);
    run_to(26);
    tests++; if (bus.dig_n !== 4'hE || bus.seg_n !== 7'h40) begin fails++; $display("FAIL zb_d0: dig %h seg %h want e 40", bus.dig_n, bus.seg_n); end
    run_to(32);
    tests++; if (bus.dig_n !== 4'hD || bus.seg_n !== 7'h12) begin fails++; $display("FAIL zb_d1: dig %h seg %h want d 12", bus.dig_n, bus.seg_n); end
`ifdef LEADING_ZERO_BLANK_EN
    run_to(38);
    tests++; if (bus.dig_n !== 4'hF) begin fails++; $display("FAIL zb_d2: dig %h want f", bus.dig_n); end
    run_to(44);
    tests++; if (bus.dig_n !== 4'hF) begin fails++; $display("FAIL zb_d3: dig %h want f", bus.dig_n); end
`else
    run_to(38);
    tests++; if (bus.dig_n !== 4'hB || bus.seg_n !== 7'h40) begin fails++; $display("FAIL zb_d2: dig %h seg %h want b 40", bus.dig_n, bus.seg_n); end
    run_to(44);
    tests++; if (bus.dig_n !== 4'h7 || bus.seg_n !== 7'h40) begin fails++; $display("FAIL zb_d3: dig %h seg %h want 7 40", bus.dig_n, bus.seg_n); end
`endif
  endtask

  initial begin
    bus.load_data  = '0;
    bus.load_valid = 1'b0;
    bus.digit_en   = 4'hF;
    test_reset();
    test_load();
    test_backpressure();
    test_digit_en();
    test_reset_mid();
    test_zero_blank();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

endmodule
